// File: rtl/harmonic_note_player_pkg.sv
// Shared types and helpers for the harmonic note voice: envelope state encoding,
// note-to-phase-step lookup and signed saturation.
package harmonic_note_player_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int PHASE_W      = 20;

  typedef logic [2:0] env_state_t;
  localparam env_state_t ENV_IDLE    = 3'd0;  // no note, gain 0
  localparam env_state_t ENV_ATTACK  = 3'd1;  // gain ramps up to full scale
  localparam env_state_t ENV_DECAY   = 3'd2;  // gain falls toward sustain level
  localparam env_state_t ENV_SUSTAIN = 3'd3;  // gain held at sustain level
  localparam env_state_t ENV_RELEASE = 3'd4;  // gain shrinks by a quarter per beat

  // Note 0 is a rest; notes 1..63 are semitones upward from C1 at a 48 kHz sample rate.
  function automatic logic [PHASE_W-1:0] freq_step(input logic [5:0] note);
    logic [5:0]  idx;
    logic [2:0]  octave;
    logic [3:0]  semi;
    logic [11:0] base;
    idx    = note - 6'd1;
    octave = 3'(idx / 6'd12);
    semi   = 4'(idx % 6'd12);
    case (semi)
      4'd0:    base = 12'd714;
      4'd1:    base = 12'd757;
      4'd2:    base = 12'd802;
      4'd3:    base = 12'd849;
      4'd4:    base = 12'd900;
      4'd5:    base = 12'd953;
      4'd6:    base = 12'd1010;
      4'd7:    base = 12'd1070;
      4'd8:    base = 12'd1134;
      4'd9:    base = 12'd1201;
      4'd10:   base = 12'd1273;
      4'd11:   base = 12'd1348;
      default: base = 12'd714;
    endcase
    if (note == 6'd0) return '0;
    return PHASE_W'(base) << octave;
  endfunction

  function automatic logic signed [31:0] saturate(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/harmonic_note_player_if.sv
// Control and sample bus between the song reader / codec path and one note voice.
interface harmonic_note_player_if
  import harmonic_note_player_pkg::*;
#(
  parameter int NUM_HARMONICS = 3,
  parameter int SAMPLE_W      = SAMPLE_W_DEF
);
  logic                         play_enable;
  logic [5:0]                   note_to_load;
  logic [5:0]                   duration_to_load;
  logic                         load_new_note;
  logic                         beat;
  logic [2*NUM_HARMONICS-1:0]   harmonic_shift;
  logic                         generate_next_sample;
  logic                         done_with_note;
  logic signed [SAMPLE_W-1:0]   sample_out;
  logic                         new_sample_ready;

  modport master (
    output play_enable, note_to_load, duration_to_load, load_new_note, beat,
           harmonic_shift, generate_next_sample,
    input  done_with_note, sample_out, new_sample_ready
  );

  modport slave (
    input  play_enable, note_to_load, duration_to_load, load_new_note, beat,
           harmonic_shift, generate_next_sample,
    output done_with_note, sample_out, new_sample_ready
  );
endinterface

// File: rtl/harmonic_note_player_osc.sv
// One harmonic: 20-bit phase accumulator feeding a quarter-wave sine table,
// sample registered one cycle after each advance.
module harmonic_note_player_osc
  import harmonic_note_player_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       advance,
  input  logic [PHASE_W-1:0]         step,
  output logic signed [SAMPLE_W-1:0] sample
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_next;

  assign phase_next = phase + step;

  // 64 points per cycle; quadrant bits mirror and negate a 17-entry quarter table.
  function automatic logic signed [15:0] sine(input logic [5:0] idx);
    logic [4:0]  j;
    logic [14:0] mag;
    j = idx[4] ? (5'd16 - {1'b0, idx[3:0]}) : {1'b0, idx[3:0]};
    case (j)
      5'd0:    mag = 15'd0;
      5'd1:    mag = 15'd3212;
      5'd2:    mag = 15'd6393;
      5'd3:    mag = 15'd9512;
      5'd4:    mag = 15'd12539;
      5'd5:    mag = 15'd15446;
      5'd6:    mag = 15'd18204;
      5'd7:    mag = 15'd20787;
      5'd8:    mag = 15'd23170;
      5'd9:    mag = 15'd25329;
      5'd10:   mag = 15'd27245;
      5'd11:   mag = 15'd28898;
      5'd12:   mag = 15'd30273;
      5'd13:   mag = 15'd31356;
      5'd14:   mag = 15'd32137;
      5'd15:   mag = 15'd32609;
      5'd16:   mag = 15'd32767;
      default: mag = 15'd0;
    endcase
    return idx[5] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase  <= '0;
      sample <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (advance) begin
      phase  <= phase_next;
      sample <= SAMPLE_W'(sine(phase_next[PHASE_W-1 -: 6])) <<< (SAMPLE_W - 16);
    end
  end

endmodule

// File: rtl/harmonic_note_player.sv
// Note voice: duration counter, beat-driven ADSR envelope and a 4-stage
// harmonic mix / saturate / gain pipeline answering codec requests.
module harmonic_note_player
  import harmonic_note_player_pkg::*;
#(
  parameter int NUM_HARMONICS = 3,
  parameter int SAMPLE_W      = SAMPLE_W_DEF,
  parameter int ATTACK_STEP   = 64,
  parameter int DECAY_STEP    = 16,
  parameter int SUSTAIN_LEVEL = 192,
  parameter int RELEASE_BEATS = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  harmonic_note_player_if.slave bus
);

  localparam int SUM_W = SAMPLE_W + $clog2(NUM_HARMONICS);

  logic [5:0]                 dur, dur_next;
  logic                       done_q;
  logic [5:0]                 note_q;
  logic [PHASE_W-1:0]         freq_q;
  env_state_t                 env_state;
  logic [7:0]                 gain;
  logic [8:0]                 gain_up;
  logic signed [9:0]          gain_dn;
  logic                       step_beat, load_ok, advance;
  logic signed [SAMPLE_W-1:0] osc_sample [NUM_HARMONICS];
  logic signed [SUM_W-1:0]    sum_c, sum_q;
  logic signed [SAMPLE_W-1:0] sat_q, sample_q;
  logic signed [SAMPLE_W+8:0] prod;
  logic [2:0]                 req_v, play_v;
  logic                       ready_q;

  assign step_beat = bus.beat && bus.play_enable && (dur != 6'd0);
  // A load on the beat that expires the current note takes effect instead of the expiry.
  assign load_ok   = bus.load_new_note && ((dur == 6'd0) || (step_beat && dur == 6'd1));
  assign advance   = bus.generate_next_sample && bus.play_enable;
  assign gain_up   = {1'b0, gain} + 9'(ATTACK_STEP);
  assign gain_dn   = $signed({2'b00, gain}) - $signed(10'(DECAY_STEP));

  always_comb begin
    dur_next = dur;
    if (load_ok)        dur_next = bus.duration_to_load;
    else if (step_beat) dur_next = dur - 6'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dur    <= '0;
      done_q <= 1'b1;
      note_q <= '0;
      freq_q <= '0;
    end else begin
      dur    <= dur_next;
      done_q <= (dur_next == 6'd0);
      if (load_ok) note_q <= bus.note_to_load;
      freq_q <= freq_step(note_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      env_state <= ENV_IDLE;
      gain      <= '0;
    end else if (load_ok) begin
      gain      <= '0;
      env_state <= (bus.duration_to_load != 6'd0) ? ENV_ATTACK : ENV_IDLE;
    end else if (step_beat) begin
      if (dur_next == 6'd0) begin
        env_state <= ENV_IDLE;
        gain      <= '0;
      end else if (env_state == ENV_RELEASE) begin
        gain <= gain - (gain >> 2);
      end else if (dur_next <= 6'(RELEASE_BEATS)) begin
        env_state <= ENV_RELEASE;
      end else begin
        case (env_state)
          ENV_ATTACK:
            if (gain_up >= 9'd255) begin
              gain      <= 8'd255;
              env_state <= ENV_DECAY;
            end else begin
              gain <= gain_up[7:0];
            end
          ENV_DECAY:
            if (gain_dn <= $signed(10'(SUSTAIN_LEVEL))) begin
              gain      <= 8'(SUSTAIN_LEVEL);
              env_state <= ENV_SUSTAIN;
            end else begin
              gain <= gain_dn[7:0];
            end
          default: ;
        endcase
      end
    end
  end

  for (genvar k = 0; k < NUM_HARMONICS; k++) begin : g_osc
    harmonic_note_player_osc #(.SAMPLE_W(SAMPLE_W)) u_osc (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (load_ok),
      .advance (advance),
      .step    (PHASE_W'(freq_q * (k + 1))),
      .sample  (osc_sample[k])
    );
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NUM_HARMONICS; k++)
      sum_c = sum_c + (SUM_W'(osc_sample[k]) >>> bus.harmonic_shift[2*k +: 2]);
  end

  assign prod = (SAMPLE_W+9)'(sat_q) * $signed({{SAMPLE_W{1'b0}}, gain});

  // Data stages run every cycle; the valid/play shift registers pick out request slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_v    <= '0;
      play_v   <= '0;
      sum_q    <= '0;
      sat_q    <= '0;
      sample_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      req_v   <= {req_v[1:0], bus.generate_next_sample};
      play_v  <= {play_v[1:0], advance};
      sum_q   <= sum_c;
      sat_q   <= SAMPLE_W'(saturate(32'(sum_q), SAMPLE_W));
      ready_q <= req_v[2];
      if (req_v[2]) sample_q <= play_v[2] ? SAMPLE_W'(prod >>> 8) : '0;
    end
  end

  assign bus.done_with_note   = done_q;
  assign bus.sample_out       = sample_q;
  assign bus.new_sample_ready = ready_q;

endmodule

// File: tb/tb_harmonic_note_player.sv
// Directed bench for harmonic_note_player: duration, envelope, pipeline latency,
// saturation, pause and reset behaviour against hand-computed values.
module tb_harmonic_note_player;
  import harmonic_note_player_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   n_ready;
  logic exp_rdy;

  int exp_gain  [20] = '{64, 128, 192, 255, 239, 223, 207, 192, 192, 192,
                         192, 192, 192, 192, 192, 192, 144, 108, 81, 0};
  int exp_state [20] = '{1, 1, 1, 2, 2, 2, 2, 3, 3, 3,
                         3, 3, 3, 3, 3, 4, 4, 4, 4, 0};

  harmonic_note_player_if bus ();

  harmonic_note_player dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_beat();
    bus.beat = 1'b1;
    tick();
    bus.beat = 1'b0;
  endtask

  task automatic load_note(input logic [5:0] note, input logic [5:0] d);
    bus.note_to_load     = note;
    bus.duration_to_load = d;
    bus.load_new_note    = 1'b1;
    tick();
    bus.load_new_note    = 1'b0;
  endtask

  task automatic do_request(input logic [15:0] exp, input bit chk);
    bus.generate_next_sample = 1'b1;
    tick();
    bus.generate_next_sample = 1'b0;
    tick();
    tick();
    check("lat_early", 32'(bus.new_sample_ready), 32'd0);
    tick();
    check("lat_ready", 32'(bus.new_sample_ready), 32'd1);
    if (chk) check("sample", 32'($unsigned(bus.sample_out)), 32'(exp));
  endtask

  initial begin
    reset_n                  = 1'b0;
    bus.play_enable          = 1'b1;
    bus.note_to_load         = '0;
    bus.duration_to_load     = '0;
    bus.load_new_note        = 1'b0;
    bus.beat                 = 1'b0;
    bus.harmonic_shift       = '0;
    bus.generate_next_sample = 1'b0;
    tick();
    tick();
    check("rst_done",   32'(bus.done_with_note), 32'd1);
    check("rst_sample", 32'($unsigned(bus.sample_out)), 32'd0);
    check("rst_ready",  32'(bus.new_sample_ready), 32'd0);
    check("rst_gain",   32'(dut.gain), 32'd0);
    check("rst_state",  32'(dut.env_state), 32'(ENV_IDLE));
    reset_n = 1'b1;
    tick();

    // duration countdown
    load_note(6'd49, 6'd10);
    check("t1_done_load", 32'(bus.done_with_note), 32'd0);
    for (int b = 1; b <= 9; b++) do_beat();
    check("t1_dur9",  32'(dut.dur), 32'd1);
    check("t1_done9", 32'(bus.done_with_note), 32'd0);
    do_beat();
    check("t1_done10", 32'(bus.done_with_note), 32'd1);

    // full envelope over a 20-beat note
    load_note(6'd49, 6'd20);
    for (int b = 0; b < 20; b++) begin
      do_beat();
      check($sformatf("t2_gain_b%0d", b + 1), 32'(dut.gain), 32'(exp_gain[b]));
      check($sformatf("t2_state_b%0d", b + 1), 32'(dut.env_state), 32'(exp_state[b]));
    end
    check("t2_done", 32'(bus.done_with_note), 32'd1);

    // saturation: note 49 step 11424, requests 4..9 drive all three harmonics high
    load_note(6'd49, 6'd20);
    for (int b = 0; b < 4; b++) do_beat();
    check("t4_gain255", 32'(dut.gain), 32'd255);
    for (int n = 1; n <= 9; n++) do_request(16'h7F7F, n >= 4);
    bus.harmonic_shift = 6'b111111;
    do_request(16'h26D3, 1'b1);
    bus.harmonic_shift = '0;

    // requests every 3 cycles, last two paused
    n_ready = 0;
    for (int i = 0; i < 24; i++) begin
      bus.generate_next_sample = (i % 3 == 0) && (i < 18);
      bus.play_enable          = !((i >= 12) && (i < 18));
      tick();
      exp_rdy = (i >= 3) && ((i - 3) % 3 == 0) && ((i - 3) < 18);
      check($sformatf("t3_ready_c%0d", i + 1), 32'(bus.new_sample_ready), 32'(exp_rdy));
      if (bus.new_sample_ready) n_ready++;
      if (exp_rdy && (i - 3) >= 12)
        check("t3_paused_zero", 32'($unsigned(bus.sample_out)), 32'd0);
    end
    bus.generate_next_sample = 1'b0;
    bus.play_enable          = 1'b1;
    check("t3_count", 32'(n_ready), 32'd6);
    check("t3_phase", 32'(dut.g_osc[0].u_osc.phase), 32'd159936);

    // pause holds duration, gain and phase
    bus.play_enable = 1'b0;
    for (int b = 0; b < 5; b++) do_beat();
    check("t5_dur_hold",  32'(dut.dur), 32'd16);
    check("t5_gain_hold", 32'(dut.gain), 32'd255);
    do_request(16'h0000, 1'b1);
    check("t5_phase_hold", 32'(dut.g_osc[0].u_osc.phase), 32'd159936);
    bus.play_enable = 1'b1;
    do_beat();
    check("t5_dur_resume",  32'(dut.dur), 32'd15);
    check("t5_gain_resume", 32'(dut.gain), 32'd239);
    do_request(16'h0000, 1'b0);
    check("t5_phase_resume", 32'(dut.g_osc[0].u_osc.phase), 32'd171360);

    // load on the final beat, then asynchronous reset mid-note
    for (int b = 0; b < 14; b++) do_beat();
    check("t6_dur1", 32'(dut.dur), 32'd1);
    bus.beat             = 1'b1;
    bus.load_new_note    = 1'b1;
    bus.note_to_load     = 6'd49;
    bus.duration_to_load = 6'd5;
    tick();
    bus.beat          = 1'b0;
    bus.load_new_note = 1'b0;
    check("t6_dur_reload",  32'(dut.dur), 32'd5);
    check("t6_done_low",    32'(bus.done_with_note), 32'd0);
    check("t6_state_att",   32'(dut.env_state), 32'(ENV_ATTACK));
    tick();
    check("t6_done_low2",   32'(bus.done_with_note), 32'd0);
    do_beat();
    check("t6_state_rel",   32'(dut.env_state), 32'(ENV_RELEASE));

    bus.generate_next_sample = 1'b1;
    tick();
    bus.generate_next_sample = 1'b0;
    tick();
    reset_n = 1'b0;
    #2;
    check("t6_rst_done",   32'(bus.done_with_note), 32'd1);
    check("t6_rst_sample", 32'($unsigned(bus.sample_out)), 32'd0);
    check("t6_rst_ready",  32'(bus.new_sample_ready), 32'd0);
    check("t6_rst_dur",    32'(dut.dur), 32'd0);
    check("t6_rst_state",  32'(dut.env_state), 32'(ENV_IDLE));
    check("t6_rst_phase",  32'(dut.g_osc[0].u_osc.phase), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_inflight_gone", 32'(bus.new_sample_ready), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
